// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one external carry-free 32-bit adder between two requesters.
// The winner's operands are latched, presented to the adder for one cycle, and the registered sum is returned with its requester ID.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg, prio_next;
    logic [WIDTH-1:0] op_a_reg, op_a_next;
    logic [WIDTH-1:0] op_b_reg, op_b_next;
    logic             op_id_reg, op_id_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0] rsp_sum_reg, rsp_sum_next;

    logic       idle;
    logic [1:0] req_valid;
    logic [1:0] grant;
    logic [1:0] req_ready;

    assign idle      = (state_reg == IDLE);
    assign req_valid = {req1_valid, req0_valid};

    // A requester wins when it is alone, or when both ask and the pointer favours it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign grant[gi]     = req_valid[gi] & (~req_valid[1-gi] | (prio_reg == 1'(gi)));
            assign req_ready[gi] = idle & grant[gi] & ~reset;
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    assign add_a     = op_a_reg;
    assign add_b     = op_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign busy      = ~idle;

    always_comb begin
        state_next     = state_reg;
        prio_next      = prio_reg;
        op_a_next      = op_a_reg;
        op_b_next      = op_b_reg;
        op_id_next     = op_id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_sum_next   = rsp_sum_reg;
        case (state_reg)
            IDLE: begin
                if (|grant) begin
                    op_a_next  = grant[1] ? req1_a : req0_a;
                    op_b_next  = grant[1] ? req1_b : req0_b;
                    op_id_next = grant[1];
                    prio_next  = ~grant[1];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rsp_sum_next   = add_sum;
                rsp_id_next    = op_id_reg;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                // The return to IDLE costs a cycle, so no accept overlaps the response handshake.
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_id_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_sum_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            prio_reg      <= prio_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            op_id_reg     <= op_id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_sum_reg   <= rsp_sum_next;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a transaction-level predictor pushes expected results on request handshakes,
// a monitor pops them on response handshakes; the shared adder is modelled as A ^ B.
module tb_adder_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         rsp_valid, rsp_id, rsp_ready, busy;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    assign add_sum = add_a ^ add_b;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: one transaction in flight at a time, response two cycles after
    // acceptance, round-robin among simultaneous requesters starting with req0.
    bit m_out    = 1'b0;
    int m_age    = 0;
    bit m_prio   = 1'b0;
    bit rst_prev = 1'b0;

    always @(negedge clk) begin
        logic e0, e1, w;
        exp_t e;
        e0 = 1'b0;
        e1 = 1'b0;
        w  = 1'b0;
        if (reset) begin
            chk1("ready0_in_reset", req0_ready, 1'b0);
            chk1("ready1_in_reset", req1_ready, 1'b0);
            if (rst_prev) begin
                chk1("rsp_valid_reset", rsp_valid, 1'b0);
                chk1("busy_reset", busy, 1'b0);
                chk1("rsp_id_reset", rsp_id, 1'b0);
                chk("rsp_sum_reset", rsp_sum, '0);
                chk("add_a_reset", add_a, '0);
                chk("add_b_reset", add_b, '0);
            end
            m_out  = 1'b0;
            m_age  = 0;
            m_prio = 1'b0;
            sb_q.delete();
        end else begin
            if (m_out) m_age++;
            if (!m_out && (req0_valid || req1_valid)) begin
                w  = (req0_valid && req1_valid) ? m_prio : req1_valid;
                e0 = (w == 1'b0);
                e1 = (w == 1'b1);
            end
            chk1("req0_ready", req0_ready, e0);
            chk1("req1_ready", req1_ready, e1);
            chk1("busy", busy, m_out);
            chk1("rsp_valid", rsp_valid, m_out && m_age >= 2);
            if (e0 || e1) begin
                e.id  = w;
                e.sum = w ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
                sb_q.push_back(e);
                m_out  = 1'b1;
                m_age  = 0;
                m_prio = ~w;
            end else if (m_out && m_age >= 2 && rsp_ready) begin
                m_out = 1'b0;
            end
        end
        rst_prev = reset;
    end

    // Monitor: compares every presented response against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%b sum=%h expected no response at %0t", rsp_id, rsp_sum, $time);
            end else begin
                chk1("rsp_id", rsp_id, sb_q[0].id);
                chk("rsp_sum", rsp_sum, sb_q[0].sum);
                if (rsp_ready) begin
                    n_rsp++;
                    $display("rsp %0d: id=%0d sum=%h (exp id=%0d sum=%h) t=%0t",
                             n_rsp, rsp_id, rsp_sum, sb_q[0].id, sb_q[0].sum, $time);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the handshake edge of the chosen requester.
    task automatic wait_accept(input bit which);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = which ? req1_ready : req0_ready;
            if (!got) step();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready expected ready on req%0d at %0t", which, $time);
        end else begin
            step();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single request
        req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0F0F;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        repeat (4) step();

        // Contention straight after reset
        pulse_reset();
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_FFFF;
        req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h1234_5678;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        wait_accept(1'b1);
        req1_valid = 1'b0;
        repeat (4) step();

        // Fairness under continuous contention
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'hA5A5_0001; req0_b = 32'h0F0F_F0F0;
        req1_a = 32'h5A5A_0002; req1_b = 32'h3C3C_C3C3;
        repeat (19) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Backpressure while req1 waits
        req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_b = 32'h0000_FFFF;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hCAFE_F00D; req1_b = 32'h1111_1111;
        rsp_ready = 1'b0;
        repeat (6) step();
        rsp_ready = 1'b1;
        wait_accept(1'b1);
        req1_valid = 1'b0;
        repeat (4) step();

        // Reset during ISSUE, then contended grant must go to req0
        req0_valid = 1'b1; req0_a = 32'h1357_9BDF; req0_b = 32'h2468_ACE0;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        pulse_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_accept(1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Reset during RESP
        req0_valid = 1'b1; req0_a = 32'h0F1E_2D3C; req0_b = 32'h4B5A_6978;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        pulse_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_accept(1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // req1 changes operands while req0 owns the adder
        req0_valid = 1'b1; req0_a = 32'h0000_1111; req0_b = 32'h0000_2222;
        req1_valid = 1'b0;
        wait_accept(1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hAAAA_0000; req1_b = 32'h0000_5555;
        step();
        req1_a = 32'h8765_4321; req1_b = 32'h1111_2222;
        step();
        req1_a = 32'hF0F0_0F0F; req1_b = 32'h00FF_FF00;
        wait_accept(1'b1);
        req1_valid = 1'b0;
        repeat (4) step();

        // Randomized traffic with backpressure and occasional reset
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
